// File: rtl/sad_pkg.sv
// Shared types and width helpers for the SAD minimum-search engine.
// Holds the FSM state enum, clog2 and the derived-width functions.
package sad_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int rowsum_w(input int pix_w, input int face_pix);
    return pix_w + clog2(face_pix);
  endfunction

  function automatic int cnt_w(input int rows);
    return clog2(rows + 1);
  endfunction

  // Widths for the default configuration.
  localparam int ROWSUM_W = rowsum_w(8, 32);
  localparam int CNT_W    = cnt_w(32);

endpackage

// File: rtl/sad_row_kernel.sv
// One candidate lane: abs-diff, registered row sum, saturating accumulator.
// Ports: i_clr clears, i_en marks an accepted row, o_acc is the running SAD.
module sad_row_kernel
  import sad_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int FACE_PIX = 32,
  parameter int SAD_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clr,
  input  logic                      i_en,
  input  logic [FACE_PIX*PIX_W-1:0] i_face,
  input  logic [FACE_PIX*PIX_W-1:0] i_win,
  output logic [SAD_W-1:0]          o_acc
);

  localparam int RS_W  = rowsum_w(PIX_W, FACE_PIX);
  localparam int EXT_W = ((SAD_W > RS_W) ? SAD_W : RS_W) + 1;

  logic [PIX_W-1:0] w_pa;
  logic [PIX_W-1:0] w_pb;
  logic [PIX_W-1:0] w_ad;
  logic [RS_W-1:0]  w_rowsum;
  logic [RS_W-1:0]  r_rowsum;
  logic             r_vld;
  logic [SAD_W-1:0] r_acc;
  logic [EXT_W-1:0] w_sum;
  logic             w_ovf;

  always_comb begin
    w_rowsum = '0;
    w_pa     = '0;
    w_pb     = '0;
    w_ad     = '0;
    for (int i = 0; i < FACE_PIX; i++) begin
      w_pa = i_face[i*PIX_W +: PIX_W];
      w_pb = i_win[i*PIX_W +: PIX_W];
      w_ad = (w_pa > w_pb) ? w_pa - w_pb
                           : w_pb - w_pa;
      w_rowsum = w_rowsum + RS_W'(w_ad);
    end
  end

  // Any bit above SAD_W means the true sum passed 2^SAD_W-1.
  assign w_sum = EXT_W'(r_acc) + EXT_W'(r_rowsum);
  assign w_ovf = |w_sum[EXT_W-1:SAD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowsum <= '0;
      r_vld    <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_rowsum <= w_rowsum;
      r_vld    <= i_en & ~i_clr;
      if (i_clr)
        r_acc <= '0;
      else if (r_vld)
        r_acc <= w_ovf ? '1 : w_sum[SAD_W-1:0];
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/sad_min_search.sv
// SAD minimum search over NUM_CAND shifted candidates, with running minimum.
// Ports: start/keep_min/pos_base job setup, row_valid/row_ready rows, done/best_* results.
module sad_min_search
  import sad_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int FACE_PIX = 32,
  parameter int NUM_CAND = 4,
  parameter int ROWS     = 32,
  parameter int SAD_W    = 32,
  parameter int POS_W    = 11
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               keep_min,
  input  logic [POS_W-1:0]                   pos_base,
  input  logic                               row_valid,
  output logic                               row_ready,
  input  logic [FACE_PIX*PIX_W-1:0]          face,
  input  logic [(FACE_PIX+NUM_CAND)*PIX_W-1:0] group,
  output logic                               busy,
  output logic                               done,
  output logic [POS_W-1:0]                   best_pos,
  output logic [SAD_W-1:0]                   best_sad
);

  localparam int C_W   = cnt_w(ROWS);
  localparam int IDX_W = (NUM_CAND > 1) ? clog2(NUM_CAND) : 1;

  state_t           r_state;
  logic [C_W-1:0]   r_cnt;
  logic             r_drain;
  logic             r_keep;
  logic [POS_W-1:0] r_base;

  logic             w_accept;
  logic             w_clr;
  logic [SAD_W-1:0] w_acc [NUM_CAND];
  logic [SAD_W-1:0] w_min_sad;
  logic [IDX_W-1:0] w_min_idx;
  logic             w_take;
  logic             w_unused;

  assign w_accept = row_valid & row_ready;
  assign w_clr    = (r_state == S_IDLE) & start;
  // The last window pixel is never covered by any candidate.
  assign w_unused = ^group[(FACE_PIX+NUM_CAND)*PIX_W-1 -: PIX_W];

  for (genvar c = 0; c < NUM_CAND; c++) begin : g_cand
    sad_row_kernel #(
      .PIX_W    (PIX_W),
      .FACE_PIX (FACE_PIX),
      .SAD_W    (SAD_W)
    ) u_kernel (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_accept),
      .i_face (face),
      .i_win  (group[c*PIX_W +: FACE_PIX*PIX_W]),
      .o_acc  (w_acc[c])
    );
  end

  // Strict compare in ascending order keeps the lowest index on ties.
  always_comb begin
    w_min_sad = w_acc[0];
    w_min_idx = '0;
    for (int c = 1; c < NUM_CAND; c++) begin
      if (w_acc[c] < w_min_sad) begin
        w_min_sad = w_acc[c];
        w_min_idx = IDX_W'(c);
      end
    end
  end

  assign w_take = ~r_keep | (w_min_sad < best_sad);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_drain   <= 1'b0;
      r_keep    <= 1'b0;
      r_base    <= '0;
      row_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      best_pos  <= '0;
      best_sad  <= '1;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_ACCUM;
            r_cnt     <= '0;
            r_keep    <= keep_min;
            r_base    <= pos_base;
            row_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_W'(ROWS - 1)) begin
              r_state   <= S_DRAIN;
              r_drain   <= 1'b0;
              row_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (r_drain)
            r_state <= S_COMPARE;
          else
            r_drain <= 1'b1;
        end
        S_COMPARE: begin
          if (w_take) begin
            best_sad <= w_min_sad;
            best_pos <= r_base + POS_W'(w_min_idx);
          end
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_min_search.sv
// Scoreboard bench for sad_min_search (default and SAD_W=12 instances).
// Driver pushes expected results; negedge monitors pop them on done.
module tb_sad_min_search;

  localparam int PIX_W    = 8;
  localparam int FACE_PIX = 32;
  localparam int NUM_CAND = 4;
  localparam int ROWS     = 32;
  localparam int POS_W    = 11;
  localparam int GP       = FACE_PIX + NUM_CAND;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic keep_min;
  logic row_valid;
  logic [POS_W-1:0] pos_base;
  logic [FACE_PIX*PIX_W-1:0] face;
  logic [GP*PIX_W-1:0] group;

  logic rr0, busy0, done0;
  logic [POS_W-1:0] pos0;
  logic [31:0] sad0;
  logic rr1, busy1, done1;
  logic [POS_W-1:0] pos1;
  logic [11:0] sad1;

  sad_min_search dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .keep_min(keep_min), .pos_base(pos_base),
    .row_valid(row_valid), .row_ready(rr0),
    .face(face), .group(group), .busy(busy0),
    .done(done0), .best_pos(pos0), .best_sad(sad0)
  );

  sad_min_search #(.SAD_W(12)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .keep_min(keep_min), .pos_base(pos_base),
    .row_valid(row_valid), .row_ready(rr1),
    .face(face), .group(group), .busy(busy1),
    .done(done1), .best_pos(pos1), .best_sad(sad1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int     pos;
    longint sad;
    int     cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  logic [7:0] fa [FACE_PIX];
  logic [7:0] ga [GP];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        chk("dut0_unexpected_done", 1, 0);
      end else begin
        e0 = q0.pop_front();
        chk("dut0_pos", 64'(pos0), 64'(e0.pos));
        chk("dut0_sad", 64'(sad0), 64'(e0.sad));
        chk("dut0_done_cycle", 64'(cyc), 64'(e0.cyc));
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_pos", 64'(pos1), 64'(e1.pos));
        chk("dut1_sad", 64'(sad1), 64'(e1.sad));
        chk("dut1_done_cycle", 64'(cyc), 64'(e1.cyc));
      end
    end
  end

  task automatic set_pat(input int f, input int g);
    for (int i = 0; i < FACE_PIX; i++) fa[i] = 8'(f);
    for (int i = 0; i < GP; i++) ga[i] = 8'(g);
  endtask

  task automatic set_row(input bit act);
    for (int i = 0; i < FACE_PIX; i++)
      face[i*PIX_W +: PIX_W] = act ? fa[i] : 8'd0;
    for (int i = 0; i < GP; i++)
      group[i*PIX_W +: PIX_W] = act ? ga[i] : 8'd0;
  endtask

  task automatic check_reset_vals();
    chk("rst_ready0", 64'(rr0), 0);
    chk("rst_busy0", 64'(busy0), 0);
    chk("rst_done0", 64'(done0), 0);
    chk("rst_pos0", 64'(pos0), 0);
    chk("rst_sad0", 64'(sad0), 64'hFFFF_FFFF);
    chk("rst_ready1", 64'(rr1), 0);
    chk("rst_busy1", 64'(busy1), 0);
    chk("rst_done1", 64'(done1), 0);
    chk("rst_pos1", 64'(pos1), 0);
    chk("rst_sad1", 64'(sad1), 64'hFFF);
  endtask

  task automatic run_job(input bit keep, input int base,
                         input int n_act, input bit gaps,
                         input int e_pos, input longint e_sad0,
                         input longint e_sad1);
    int t, k, sent, guard;
    bit ph;
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    keep_min = keep;
    pos_base = POS_W'(base);
    t = cyc;
    @(negedge clk);
    start = 1'b0;
    keep_min = ~keep;
    pos_base = ~POS_W'(base);
    chk("busy_after_start", 64'(busy0), 1);
    chk("ready_after_start", 64'(rr0), 1);
    sent = 0;
    guard = 0;
    ph = 1'b0;
    k = 0;
    while (sent < ROWS && guard < 400) begin
      set_row(sent < n_act);
      row_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      start = gaps && (sent == 5 || sent == ROWS - 1);
      if (row_valid && rr0) begin
        sent++;
        if (sent == ROWS) begin
          k = cyc;
          e.pos = e_pos;
          e.cyc = gaps ? k + 4 : t + ROWS + 4;
          e.sad = e_sad0;
          q0.push_back(e);
          e.sad = e_sad1;
          q1.push_back(e);
        end
      end
      @(negedge clk);
      guard++;
    end
    row_valid = 1'b0;
    start = 1'b0;
    set_row(1'b0);
    if (sent < ROWS) begin
      chk("row_accept_timeout", 64'(sent), 64'(ROWS));
    end else begin
      repeat (3) @(negedge clk);
      chk("busy_in_done", 64'(busy0), 1);
      @(negedge clk);
      chk("busy_after_done", 64'(busy0), 0);
      chk("ready_after_done", 64'(rr0), 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic abort_job(input int n_rows);
    int sent, guard;
    @(negedge clk);
    start = 1'b1;
    keep_min = 1'b0;
    pos_base = '0;
    @(negedge clk);
    start = 1'b0;
    sent = 0;
    guard = 0;
    while (sent < n_rows && guard < 100) begin
      set_row(1'b1);
      row_valid = 1'b1;
      if (rr0) sent++;
      @(negedge clk);
      guard++;
    end
    rst_n = 1'b0;
    row_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_rows_sent", 64'(sent), 64'(n_rows));
    check_reset_vals();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    keep_min = 1'b0;
    pos_base = '0;
    row_valid = 1'b0;
    face = '0;
    group = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    set_pat(10, 10);
    ga[0] = 8'd0; ga[1] = 8'd0; ga[34] = 8'd0; ga[35] = 8'd0;
    run_job(1'b0, 0, 32, 1'b0, 2, 0, 0);

    set_pat(10, 11);
    run_job(1'b0, 7, 32, 1'b0, 7, 1024, 1024);

    set_pat(0, 255);
    run_job(1'b0, 0, 32, 1'b0, 0, 261120, 4095);

    set_pat(0, 0);
    ga[0] = 10; ga[3] = 20; ga[32] = 5; ga[33] = 10; ga[34] = 5;
    run_job(1'b0, 0, 20, 1'b0, 1, 500, 500);

    set_pat(0, 0);
    ga[0] = 10; ga[1] = 10; ga[3] = 10;
    ga[32] = 10; ga[33] = 5; ga[34] = 15;
    run_job(1'b1, 4, 20, 1'b0, 1, 500, 500);

    set_pat(0, 0);
    ga[2] = 15; ga[3] = 5; ga[32] = 5; ga[33] = 5;
    run_job(1'b1, 8, 20, 1'b0, 11, 300, 300);

    set_pat(10, 10);
    ga[0] = 8'd0; ga[1] = 8'd0; ga[34] = 8'd0; ga[35] = 8'd0;
    run_job(1'b0, 3, 32, 1'b1, 5, 0, 0);

    set_pat(10, 11);
    abort_job(10);

    set_pat(10, 10);
    ga[0] = 8'd0; ga[1] = 8'd0; ga[34] = 8'd0; ga[35] = 8'd0;
    run_job(1'b1, 0, 32, 1'b0, 2, 0, 0);

    repeat (5) @(negedge clk);
    chk("pending_dut0", 64'(q0.size()), 0);
    chk("pending_dut1", 64'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
